// File: rtl/boot_mem_loader.sv
// Boot memory loader.
// Accepts a framed little-endian byte stream (BASE, COUNT, COUNT data words, XOR checksum).
// Writes each data word to the CPU data memory through its external write port
// while holding the CPU in reset, and releases the CPU only after the checksum matches.
module boot_mem_loader #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        reload,
  output logic        cpu_reset,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_DataAdr,
  output logic [31:0] Ext_WriteData,
  output logic        done,
  output logic        error
);

  localparam int unsigned HDR_W     = 32 + CNT_W;
  localparam int unsigned HDR_BYTES = HDR_W / 8;
  localparam logic [2:0]  HDR_LAST  = 3'(HDR_BYTES - 1);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_RUN,
    S_ERR
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [HDR_W-1:0] hdr;         // {COUNT, BASE} once the header is complete
  logic [HDR_W-1:0] hdr_shift;
  logic [2:0]       hdr_cnt;     // header bytes accepted so far
  logic [1:0]       byte_cnt;    // byte position inside the current word
  logic [31:0]      word;
  logic [31:0]      word_shift;
  logic [CNT_W-1:0] idx;         // index of the word being assembled
  logic [CNT_W-1:0] idx_inc;
  logic [7:0]       acc;         // running XOR of every frame byte before CHK
  logic [31:0]      idle;        // cycles since the last accepted byte
  logic             accept;
  logic             timed;
  logic             timeout_hit;
  logic [31:0]      base;
  logic [CNT_W-1:0] count;

  // Little-endian fields land in place because bytes enter from the top.
  assign hdr_shift  = {in_data, hdr[HDR_W-1:8]};
  assign word_shift = {in_data, word[31:8]};
  assign base       = hdr[31:0];
  assign count      = hdr[HDR_W-1:32];
  assign idx_inc    = idx + CNT_W'(1);

  assign in_ready = (state == S_HDR) || (state == S_DATA) || (state == S_CHK);
  assign done     = (state == S_RUN);
  assign error    = (state == S_ERR);
  assign accept   = in_valid && in_ready;

  // The idle watchdog only runs while a frame is actually in progress.
  assign timed       = (state == S_DATA) || (state == S_CHK) ||
                       ((state == S_HDR) && (hdr_cnt != 3'd0));
  assign timeout_hit = (TIMEOUT != 0) && timed && !accept && (idle == TIMEOUT - 1);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) state <= S_HDR;
    else        state <= state_next;
  end

  // Next-state selection; reload overrides everything, including a same-cycle byte.
  always_comb begin
    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    state_next = state;
    case (state)
      S_HDR: begin
        if (timeout_hit) begin
          state_next = S_ERR;
        end else if (accept && (hdr_cnt == HDR_LAST)) begin
          if (hdr_shift[1:0] != 2'b00)           state_next = S_ERR;
          else if (hdr_shift[HDR_W-1:32] == '0)  state_next = S_CHK;
          else                                   state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (timeout_hit)                          state_next = S_ERR;
        else if (accept && (byte_cnt == 2'd3))    state_next = S_WRITE;
      end
      S_WRITE: begin
        state_next = (idx_inc == count) ? S_CHK : S_DATA;
      end
      S_CHK: begin
        if (timeout_hit)  state_next = S_ERR;
        else if (accept)  state_next = (in_data == acc) ? S_RUN : S_ERR;
      end
      default: state_next = state;
    endcase
    if (reload) state_next = S_HDR;
  end

  // Datapath: header/word assembly, checksum, idle counter, write port and CPU reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr           <= '0;
      hdr_cnt       <= '0;
      byte_cnt      <= '0;
      word          <= '0;
      idx           <= '0;
      acc           <= '0;
      idle          <= '0;
      cpu_reset     <= 1'b1;
      Ext_MemWrite  <= 1'b0;
      Ext_DataAdr   <= '0;
      Ext_WriteData <= '0;
    end else begin
      // Registered from the state so the CPU only leaves reset the cycle after RUN is entered.
      cpu_reset    <= reload || (state != S_RUN);
      // The strobe follows the latch cycle, so address and data are already stable.
      Ext_MemWrite <= (state == S_WRITE) && !reload;
      if (reload) begin
        hdr      <= '0;
        hdr_cnt  <= '0;
        byte_cnt <= '0;
        word     <= '0;
        idx      <= '0;
        acc      <= '0;
        idle     <= '0;
      end else begin
        idle <= (accept || !timed) ? '0 : idle + 32'd1;
        case (state)
          S_HDR: begin
            if (accept) begin
              hdr     <= hdr_shift;
              hdr_cnt <= hdr_cnt + 3'd1;
              acc     <= acc ^ in_data;
            end
          end
          S_DATA: begin
            if (accept) begin
              word     <= word_shift;
              byte_cnt <= byte_cnt + 2'd1;
              acc      <= acc ^ in_data;
              if (byte_cnt == 2'd3) begin
                Ext_WriteData <= word_shift;
                Ext_DataAdr   <= base + (32'(idx) << 2);
              end
            end
          end
          S_WRITE: idx <= idx_inc;
          default: ;
        endcase
      end
    end
  end

endmodule
